// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V core front end.
//   - XLEN / INSTR_BYTES   : datapath width and instruction size in bytes
//   - OPC_*                : 7-bit major opcodes consumed by the control decoder
//   - fetch_state_t        : state encoding of the instruction fetch FSM
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [6:0] OPC_OP     = 7'b0110011;  // R-type
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bundles every non-clock signal of the fetch stage.
//   imem_req_*  : request to instruction memory (fetch is the initiator)
//   imem_rsp_*  : single-cycle response, no backpressure
//   redirect_*  : branch / JAL / JALR target from execute
//   if_*        : held instruction toward decode
//   fetch_misaligned : sticky misaligned-redirect flag
// Modports: master = fetch stage, slave = memory/execute/decode side.
//
// Handshake rule for both valid/ready pairs (imem_req, if): a transfer happens
// on a rising edge where valid and ready are both 1; valid never depends on
// ready, and the payload stays stable while valid is 1 and ready is 0.
// -----------------------------------------------------------------------------
interface instr_fetch_if;
    import riscv_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic [6:0]      if_opcode;
    logic            fetch_misaligned;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output if_valid, if_instr, if_pc, if_opcode,
        input  if_ready,
        output fetch_misaligned
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  if_valid, if_instr, if_pc, if_opcode,
        output if_ready,
        input  fetch_misaligned
    );

endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage: owns the PC, keeps at most one word request
// outstanding to instruction memory, and holds the returned instruction for
// decode. Redirects from execute override sequential fetch and squash any
// in-flight or held instruction.
//
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous, active-high
//   bus          : instr_fetch_if.master (imem request/response, redirect,
//                  decode handshake, misaligned flag)
//   o_dbg_state  : current FSM state, for observation only
//
// Every output is a register or a decode of the state register; no input
// reaches an output combinationally.
// -----------------------------------------------------------------------------
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_if.master        bus,
    output fetch_state_t         o_dbg_state
);

    fetch_state_t    r_state;
    fetch_state_t    w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr_q;
    logic [XLEN-1:0] r_pc_q;
    logic            r_drop;
    logic            r_misaligned;

    logic            w_redirect;
    logic            w_req_hs;
    logic            w_rsp_in_wait;
    logic            w_rsp_keep;
    logic [XLEN-1:0] w_redirect_pc;

    // Redirects are ignored in IDLE; everywhere else they are accepted.
    assign w_redirect    = bus.redirect_valid && (r_state != IDLE);
    assign w_req_hs      = (r_state == REQ) && bus.imem_req_ready;
    assign w_rsp_in_wait = (r_state == WAIT) && bus.imem_rsp_valid;
    // A response is kept only if it is not the one owed to an earlier redirect
    // and no redirect arrives alongside it (that redirect discards it too).
    assign w_rsp_keep    = w_rsp_in_wait && !r_drop && !bus.redirect_valid;
    assign w_redirect_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: w_next_state = REQ;
            // A redirect in REQ keeps the same next state: stalled stays in
            // REQ (new address), a handshake goes to WAIT (with drop set).
            REQ:  if (bus.imem_req_ready) w_next_state = WAIT;
            WAIT: if (bus.imem_rsp_valid) w_next_state = w_rsp_keep ? HOLD : REQ;
            HOLD: if (bus.if_ready || bus.redirect_valid) w_next_state = REQ;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_drop       <= 1'b0;
            r_instr_q    <= '0;
            r_pc_q       <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_redirect) begin
                r_pc <= w_redirect_pc;
            end else if (w_rsp_keep) begin
                r_pc <= r_pc + XLEN'(INSTR_BYTES);
            end

            if (w_rsp_keep) begin
                r_instr_q <= bus.imem_rsp_data;
                r_pc_q    <= r_pc;
            end

            // Any response seen in WAIT settles the outstanding request, so it
            // always clears drop; otherwise a redirect with a request in flight
            // marks that request's response for discard.
            if (w_rsp_in_wait) begin
                r_drop <= 1'b0;
            end else if (w_redirect && (w_req_hs || (r_state == WAIT))) begin
                r_drop <= 1'b1;
            end

            if (w_redirect && (bus.redirect_pc[1:0] != 2'b00)) begin
                r_misaligned <= 1'b1;
            end
        end
    end

    assign bus.imem_req_valid   = (r_state == REQ);
    assign bus.imem_req_addr    = r_pc;
    assign bus.if_valid         = (r_state == HOLD);
    assign bus.if_instr         = r_instr_q;
    assign bus.if_pc            = r_pc_q;
    assign bus.if_opcode        = r_instr_q[6:0];
    assign bus.fetch_misaligned = r_misaligned;
    assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. A cycle task plays the instruction memory
// (configurable ready and response latency), checks every request address
// against an expected-address queue, and pops the expected {pc, instr} queue
// whenever decode consumes an instruction.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
    import riscv_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    fetch_state_t dbg_state;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.master),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          consumed = 0;
    logic [63:0] exp_q[$];      // {pc, instr} expected at decode
    logic [31:0] addr_q[$];     // expected request addresses, in order

    int          lat      = 1;
    int          drop_cnt = 0;  // responses the DUT must discard
    bit          pend     = 1'b0;
    int          rem      = 0;
    logic [31:0] pend_addr = '0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        logic [6:0] opc;
        case (a[3:2])
            2'd0:    opc = OPC_OP_IMM;
            2'd1:    opc = OPC_LUI;
            2'd2:    opc = OPC_JAL;
            default: opc = OPC_BRANCH;
        endcase
        return {a[26:2], opc};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: account for handshakes seen before the edge, then model
    // the memory response for the following cycle.
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        logic [63:0] e;
        hs = bus.imem_req_valid && bus.imem_req_ready;
        a  = bus.imem_req_addr;
        if (hs) begin
            check("req_expected", 64'(addr_q.size() != 0), 64'd1);
            if (addr_q.size() != 0) check("req_addr", 64'(a), 64'(addr_q.pop_front()));
        end
        if (bus.if_valid && bus.if_ready) begin
            consumed++;
            check("consume_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("if_pc",     64'(bus.if_pc),     64'(e[63:32]));
                check("if_instr",  64'(bus.if_instr),  64'(e[31:0]));
                check("if_opcode", 64'(bus.if_opcode), 64'(e[6:0]));
            end
        end
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        if (hs) begin
            pend      = 1'b1;
            rem       = lat;
            pend_addr = a;
        end
        if (pend) begin
            rem--;
            if (rem == 0) begin
                pend = 1'b0;
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_data(pend_addr);
                if (drop_cnt > 0) drop_cnt--;
                else exp_q.push_back({pend_addr, mem_data(pend_addr)});
            end
        end
    endtask

    task automatic wait_if_valid(input int bound);
        for (int i = 0; i < bound && !bus.if_valid; i++) tick();
        check("wait_if_valid", 64'(bus.if_valid), 64'd1);
    endtask

    task automatic run_consume(input int n);
        int target;
        target = consumed + n;
        for (int i = 0; i < 60 && consumed < target; i++) tick();
        check("consume_count", 64'(consumed), 64'(target));
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
    endtask

    initial begin
        reset              = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.if_ready       = 1'b0;
        #1;
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("rst_req_addr",  64'(bus.imem_req_addr),  64'h0);
        check("rst_if_valid",  64'(bus.if_valid),       64'd0);
        check("rst_if_instr",  64'(bus.if_instr),       64'h0);
        check("rst_if_pc",     64'(bus.if_pc),          64'h0);
        check("rst_misalign",  64'(bus.fetch_misaligned), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        check("req_valid_first_cycle", 64'(bus.imem_req_valid), 64'd0);

        // Sequential fetch, ready memory, 1-cycle latency, decode always ready.
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        lat                = 1;
        addr_q.push_back(32'h0);
        addr_q.push_back(32'h4);
        addr_q.push_back(32'h8);
        run_consume(3);
        bus.imem_req_ready = 1'b0;
        bus.if_ready       = 1'b0;
        check("stall_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("stall_req_addr",  64'(bus.imem_req_addr),  64'hC);
        tick();
        check("stall_addr_stable", 64'(bus.imem_req_addr), 64'hC);

        // Decode stalls in HOLD for five cycles.
        addr_q.push_back(32'hC);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        wait_if_valid(20);
        for (int i = 0; i < 5; i++) begin
            check("hold_if_valid",  64'(bus.if_valid),       64'd1);
            check("hold_if_pc",     64'(bus.if_pc),          64'hC);
            check("hold_if_instr",  64'(bus.if_instr),       64'(mem_data(32'hC)));
            check("hold_no_req",    64'(bus.imem_req_valid), 64'd0);
            tick();
        end
        bus.if_ready = 1'b1;
        tick();
        bus.if_ready = 1'b0;
        check("after_consume_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("after_consume_req_addr",  64'(bus.imem_req_addr),  64'h10);

        // Redirect while WAIT with a 3-cycle response latency.
        lat = 3;
        addr_q.push_back(32'h10);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        redirect(32'h100);
        drop_cnt = 1;
        tick();
        for (int i = 0; i < 2; i++) begin
            check("wait_drop_if_valid",  64'(bus.if_valid),       64'd0);
            check("wait_drop_req_valid", 64'(bus.imem_req_valid), 64'd0);
            tick();
        end
        check("wait_redir_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("wait_redir_req_addr",  64'(bus.imem_req_addr),  64'h100);
        check("wait_redir_if_valid",  64'(bus.if_valid),       64'd0);
        check("aligned_no_misalign",  64'(bus.fetch_misaligned), 64'd0);
        lat = 1;
        addr_q.push_back(32'h100);
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        run_consume(1);
        bus.imem_req_ready = 1'b0;
        bus.if_ready       = 1'b0;

        // Redirect in stalled REQ, then redirect together with a handshake.
        redirect(32'h8);
        tick();
        check("req_redir_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("req_redir_req_addr",  64'(bus.imem_req_addr),  64'h8);
        addr_q.push_back(32'h8);
        bus.imem_req_ready = 1'b1;
        redirect(32'h200);
        drop_cnt = 1;
        tick();
        bus.imem_req_ready = 1'b0;
        check("hs_redir_if_valid",  64'(bus.if_valid),       64'd0);
        check("hs_redir_req_valid", 64'(bus.imem_req_valid), 64'd0);
        tick();
        check("hs_redir_next_valid", 64'(bus.imem_req_valid), 64'd1);
        check("hs_redir_next_addr",  64'(bus.imem_req_addr),  64'h200);
        check("hs_redir_if_valid2",  64'(bus.if_valid),       64'd0);

        // Misaligned redirect squashes the held instruction.
        addr_q.push_back(32'h200);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        wait_if_valid(20);
        check("hold_pc_200", 64'(bus.if_pc), 64'h200);
        redirect(32'h102);
        void'(exp_q.pop_front());
        tick();
        check("squash_if_valid",  64'(bus.if_valid),         64'd0);
        check("squash_req_valid", 64'(bus.imem_req_valid),   64'd1);
        check("squash_req_addr",  64'(bus.imem_req_addr),    64'h100);
        check("misalign_set",     64'(bus.fetch_misaligned), 64'd1);
        addr_q.push_back(32'h100);
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        run_consume(1);
        bus.imem_req_ready = 1'b0;
        bus.if_ready       = 1'b0;
        check("misalign_sticky", 64'(bus.fetch_misaligned), 64'd1);

        // Reset asserted while a request is outstanding.
        lat = 3;
        addr_q.push_back(32'h104);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_req_valid", 64'(bus.imem_req_valid),   64'd0);
        check("midrst_req_addr",  64'(bus.imem_req_addr),    64'h0);
        check("midrst_if_valid",  64'(bus.if_valid),         64'd0);
        check("midrst_if_instr",  64'(bus.if_instr),         64'h0);
        check("midrst_if_pc",     64'(bus.if_pc),            64'h0);
        check("midrst_if_opcode", 64'(bus.if_opcode),        64'h0);
        check("midrst_misalign",  64'(bus.fetch_misaligned), 64'd0);
        drop_cnt = 1;
        tick();
        reset = 1'b0;
        check("rel_req_valid", 64'(bus.imem_req_valid), 64'd0);
        tick();
        check("stale_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("stale_req_addr",  64'(bus.imem_req_addr),  64'h0);
        check("stale_if_valid",  64'(bus.if_valid),       64'd0);
        tick();
        check("stale_if_valid2", 64'(bus.if_valid),       64'd0);
        check("stale_req_hold",  64'(bus.imem_req_valid), 64'd1);

        lat = 1;
        addr_q.push_back(32'h0);
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        run_consume(1);
        bus.imem_req_ready = 1'b0;
        bus.if_ready       = 1'b0;

        check("exp_q_empty",    64'(exp_q.size()),  64'd0);
        check("addr_q_empty",   64'(addr_q.size()), 64'd0);
        check("drop_cnt_empty", 64'(drop_cnt),      64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the RISC-V core. Owns the program counter, issues one word request at a time to instruction memory over a valid/ready port, and holds the returned instruction for the decode stage. Decode receives the instruction, its PC and the 7-bit opcode field that the control decoder consumes. Branch, JAL and JALR redirects from execute override sequential fetch and squash any in-flight or held instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `imem_req_valid` output, 1 bit: fetch request valid.
- `imem_req_ready` input, 1 bit: memory accepts the request this cycle.
- `imem_req_addr` output, 32 bits: byte address; bits [1:0] are always 0.
- `imem_rsp_valid` input, 1 bit: response valid for one cycle; memory has no backpressure.
- `imem_rsp_data` input, 32 bits: instruction word.
- `redirect_valid` input, 1 bit: taken branch, JAL or JALR.
- `redirect_pc` input, 32 bits: redirect target.
- `if_valid` output, 1 bit: held instruction valid to decode.
- `if_ready` input, 1 bit: decode consumes the instruction.
- `if_instr` output, 32 bits: held instruction.
- `if_pc` output, 32 bits: address of `if_instr`.
- `if_opcode` output, 7 bits: `if_instr[6:0]`, drives the control decoder.
- `fetch_misaligned` output, 1 bit: sticky flag; set when an accepted redirect has `redirect_pc[1:0]` != 0.

## Operation
- States:
  - IDLE: reset state.
  - REQ: drive the request.
  - WAIT: one request outstanding.
  - HOLD: instruction presented to decode.
- Registers: `pc` (address of the next or current request), `drop` (discard the next response), `instr_q`, `pc_q`, state.
- IDLE -> REQ unconditionally.
- REQ: `imem_req_valid`=1, `imem_req_addr`=`pc`.
  - On `imem_req_ready` -> WAIT.
  - Otherwise stay. `imem_req_addr` is stable while stalled, except on a redirect.
- WAIT: on `imem_rsp_valid`:
  - `drop`=0: `instr_q`<=data, `pc_q`<=`pc`, `pc`<=`pc`+4 (mod 2^32), -> HOLD.
  - `drop`=1: discard the response, clear `drop`, -> REQ.
- HOLD: `if_valid`=1.
  - On `if_ready` -> REQ, with `pc` already holding the next address.
  - Otherwise hold `if_instr`, `if_pc` and `if_opcode` stable.
- Redirect has highest priority. It is accepted in any state except IDLE. On a redirect, `pc`<={`redirect_pc`[31:2],2'b00}, and if `redirect_pc[1:0]` != 0, `fetch_misaligned`<=1.
  - REQ, no handshake this cycle: stay in REQ with the new address.
  - REQ with handshake this cycle: the request for the old `pc` is in flight, so set `drop`, -> WAIT.
  - WAIT: set `drop`, stay in WAIT. A response arriving in the same cycle counts as the dropped one: discard it, clear `drop`, -> REQ.
  - HOLD: squash the held instruction (`if_valid`=0 from the next cycle), -> REQ. A redirect and `if_ready` in the same cycle: the instruction counts as consumed, and the redirect still wins the next-state choice.
  - In IDLE, a redirect is ignored.
- `imem_rsp_valid` outside WAIT is ignored; it does not corrupt state.
- Only one request is ever outstanding.

## Timing
- Reset values:
  - state=IDLE, `pc`=`RESET_PC`, `drop`=0, `instr_q`=0, `pc_q`=0, `fetch_misaligned`=0.
  - All outputs 0 except `imem_req_addr`=`RESET_PC`.
- `imem_req_valid`=0 during reset and the first cycle after release; it is 1 from the second cycle.
- Latency:
  - Request accepted in cycle N, response in N+k (k>=1): `if_valid`=1 in N+k+1.
  - Consume in HOLD in cycle M: the next request is driven in M+1.
  - Best-case throughput: 1 instruction per 3 cycles.
- A redirect in cycle N: `imem_req_addr` shows the target in N+1 (REQ/HOLD cases), or after the drop completes (WAIT case).
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Reset asserted mid-operation immediately returns to IDLE. A response arriving after reset release with no request outstanding is ignored.

## Structure
- Shared package `riscv_pkg` holds:
  - the opcode constants (R-type, LOAD, STORE, OP-IMM, BRANCH, JAL, JALR, LUI, AUIPC);
  - `fetch_state_t` (IDLE, REQ, WAIT, HOLD);
  - `XLEN`=32 and `INSTR_BYTES`=4.
- No sub-module: single module with one state register, one next-state `always_comb`, and one register block.

## Test plan
- Reset release, `imem_req_ready`=1, 1-cycle response latency, `if_ready`=1:
  - addresses 0x0, 0x4, 0x8 are issued;
  - `if_pc` follows them;
  - `if_opcode` equals `imem_rsp_data[6:0]` (e.g. 0x00000013 -> 7'b0010011).
- `if_ready`=0 for 5 cycles in HOLD:
  - `if_instr` and `if_pc` stay stable;
  - no new request is issued;
  - raising `if_ready` -> request for `if_pc`+4 the next cycle.
- Redirect to 0x100 while in WAIT with 3-cycle response latency: the response for the old PC is dropped, `if_valid` stays 0, and the next request address is 0x100.
- Redirect to 0x200 in the same cycle as a REQ handshake to 0x8: the response is discarded, and the next request is 0x200.
- Redirect to 0x102 in HOLD: the held instruction is squashed, the request goes to 0x100, and `fetch_misaligned`=1 and remains set.
- Reset asserted while in WAIT: outputs return to their reset values immediately. A stale response arriving 1 cycle after release produces no `if_valid`.
